renkon_ctrl_loop: RTL and testbench

Parametrised loop-nest sequencer for the renkon convolution engine. It walks output-channel groups of `CORE` cores, input channels and input pixels, and drives the weight and image read addresses for each step. It also emits the first/last-input flags, a per-group core mask and a stride-aware window-complete strobe for the downstream conv/bias/relu/pool stage chain. Compared with the fixed controller it supports any core count with partial last groups, programmable stride, a drain period, and abort.

---
 rtl/renkon_pkg.sv | 28 ++
 rtl/renkon_ctrl_loop_if.sv | 44 ++++
 rtl/renkon_ctrl_wincnt.sv | 82 ++++++++
 rtl/renkon_ctrl_loop.sv | 243 ++++++++++++++++++++++++
 tb/tb_renkon_ctrl_loop.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/renkon_pkg.sv
// Shared types for the renkon controllers: loop-sequencer state enum and the
// 2-bit core_state encoding seen by the stage controllers.
package renkon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NETLOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } ctrl_loop_state_t;

  localparam logic [1:0] CS_IDLE    = 2'd0;
  localparam logic [1:0] CS_NETLOAD = 2'd1;
  localparam logic [1:0] CS_STREAM  = 2'd2;
  localparam logic [1:0] CS_DRAIN   = 2'd3;

  // DRAIN and DONE share the same external code.
  function automatic logic [1:0] core_state_of(input ctrl_loop_state_t s);
    case (s)
      ST_NETLOAD:       return CS_NETLOAD;
      ST_STREAM:        return CS_STREAM;
      ST_DRAIN, ST_DONE: return CS_DRAIN;
      default:          return CS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/renkon_ctrl_loop_if.sv
// Control/config/read-address bundle of the loop sequencer.
//   master: issues req/abort and layer config, observes reads and flags
//   slave : the sequencer itself
interface renkon_ctrl_loop_if #(
  parameter int unsigned CORE    = 8,
  parameter int unsigned LWIDTH  = 10,
  parameter int unsigned IMGSIZE = 12,
  parameter int unsigned NETSIZE = 11
);
  logic                req;
  logic                abort;
  logic [LWIDTH-1:0]   total_in;
  logic [LWIDTH-1:0]   total_out;
  logic [LWIDTH-1:0]   img_size;
  logic [LWIDTH-1:0]   conv_size;
  logic [LWIDTH-1:0]   stride;
  logic [IMGSIZE-1:0]  in_offset;
  logic [NETSIZE-1:0]  net_offset;

  logic                ack;
  logic [1:0]          core_state;
  logic                net_re;
  logic [NETSIZE-1:0]  net_addr;
  logic                img_re;
  logic [IMGSIZE-1:0]  img_addr;
  logic                first_input;
  logic                last_input;
  logic [CORE-1:0]     core_mask;
  logic                win_oe;

  modport master (
    output req, abort, total_in, total_out, img_size, conv_size, stride,
           in_offset, net_offset,
    input  ack, core_state, net_re, net_addr, img_re, img_addr,
           first_input, last_input, core_mask, win_oe
  );

  modport slave (
    input  req, abort, total_in, total_out, img_size, conv_size, stride,
           in_offset, net_offset,
    output ack, core_state, net_re, net_addr, img_re, img_addr,
           first_input, last_input, core_mask, win_oe
  );
endinterface

// File: rtl/renkon_ctrl_wincnt.sv
// 2-D pixel counter for one input map with stride-aware window detection.
// Registers describe the pixel of the *current* cycle; win_oe is registered
// alongside them so it lines up with the registered img_re.
//   clear : return to pixel (0,0), win_oe low
//   load  : next cycle is pixel (0,0) of a map
//   adv   : next cycle is the following pixel (raster order)
//   last_c: current pixel is the final one of the map
module renkon_ctrl_wincnt #(
  parameter int unsigned LWIDTH = 10
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              clear,
  input  logic              load,
  input  logic              adv,
  input  logic [LWIDTH-1:0] img_size,
  input  logic [LWIDTH-1:0] conv_size,
  input  logic [LWIDTH-1:0] stride,
  output logic              win_oe,
  output logic              last_c
);

  localparam logic [LWIDTH-1:0] ONE = LWIDTH'(1);

  logic [LWIDTH-1:0] x, y, mx, my;
  logic [LWIDTH-1:0] x_n, y_n, mx_n, my_n;
  logic              win_n;
  logic [LWIDTH-1:0] km1, sm1, imax;

  // mx/my hold (coord - (K-1)) mod stride once the coordinate reaches K-1.
  always_comb begin
    km1   = conv_size - ONE;
    sm1   = (stride == '0) ? '0 : stride - ONE;
    imax  = img_size - ONE;
    x_n   = x;
    y_n   = y;
    mx_n  = mx;
    my_n  = my;
    win_n = 1'b0;
    if (clear || load) begin
      x_n  = '0;
      y_n  = '0;
      mx_n = '0;
      my_n = '0;
    end else if (adv) begin
      if (x == imax) begin
        x_n  = '0;
        mx_n = '0;
        y_n  = y + ONE;
        if (y_n <= km1)     my_n = '0;
        else if (my == sm1) my_n = '0;
        else                my_n = my + ONE;
      end else begin
        x_n = x + ONE;
        if (x_n <= km1)     mx_n = '0;
        else if (mx == sm1) mx_n = '0;
        else                mx_n = mx + ONE;
      end
    end
    if (!clear && (load || adv))
      win_n = (x_n >= km1) && (y_n >= km1) && (mx_n == '0) && (my_n == '0);
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      x      <= '0;
      y      <= '0;
      mx     <= '0;
      my     <= '0;
      win_oe <= 1'b0;
    end else begin
      x      <= x_n;
      y      <= y_n;
      mx     <= mx_n;
      my     <= my_n;
      win_oe <= win_n;
    end
  end

  assign last_c = (x == imax) && (y == imax);

endmodule

// File: rtl/renkon_ctrl_loop.sv
// Loop-nest sequencer: groups of CORE output channels x input channels x
// pixels. Drives weight/pixel read addresses, channel flags, core mask and
// the window-complete strobe. All outputs are registered: the next-state
// block computes the values for the coming cycle.
//   clk, xrst : clock, async active-low reset
//   bus       : req/abort/config in; ack, core_state, reads, flags out
module renkon_ctrl_loop
  import renkon_pkg::*;
#(
  parameter int unsigned CORE    = 8,
  parameter int unsigned LWIDTH  = 10,
  parameter int unsigned IMGSIZE = 12,
  parameter int unsigned NETSIZE = 11,
  parameter int unsigned DRAIN   = 4
) (
  input  logic             clk,
  input  logic             xrst,
  renkon_ctrl_loop_if.slave bus
);

  localparam logic [LWIDTH-1:0] ONE        = LWIDTH'(1);
  localparam logic [LWIDTH-1:0] CORE_L     = LWIDTH'(CORE);
  localparam logic [LWIDTH-1:0] DRAIN_LAST = (DRAIN == 0) ? '0 : LWIDTH'(DRAIN - 1);

  ctrl_loop_state_t    state, state_n;
  logic [LWIDTH-1:0]   in_idx, in_idx_n;
  logic [LWIDTH-1:0]   rem, rem_n;        // output channels left, current group included
  logic [LWIDTH-1:0]   kx, kx_n, ky, ky_n;
  logic [LWIDTH-1:0]   dcnt, dcnt_n;
  logic [NETSIZE-1:0]  net_addr, net_addr_n;
  logic [IMGSIZE-1:0]  img_addr, img_addr_n;
  logic                ack, ack_n;
  logic [1:0]          core_state, core_state_n;
  logic                net_re, net_re_n;
  logic                img_re, img_re_n;
  logic                first_input, first_n;
  logic                last_input, last_n;
  logic [CORE-1:0]     core_mask, mask_n;
  logic                wc_clear, wc_load, wc_adv;
  logic                wc_last, win_oe;
  logic [LWIDTH-1:0]   kmax, in_last;

  // Low r bits set, saturating at all ones.
  function automatic logic [CORE-1:0] mask_for(input logic [LWIDTH-1:0] r);
    logic [CORE-1:0] m;
    m = '0;
    for (int b = 0; b < int'(CORE); b++) m[b] = (LWIDTH'(b) < r);
    return m;
  endfunction

  renkon_ctrl_wincnt #(.LWIDTH(LWIDTH)) u_wincnt (
    .clk       (clk),
    .xrst      (xrst),
    .clear     (wc_clear),
    .load      (wc_load),
    .adv       (wc_adv),
    .img_size  (bus.img_size),
    .conv_size (bus.conv_size),
    .stride    (bus.stride),
    .win_oe    (win_oe),
    .last_c    (wc_last)
  );

  // Next state and next output values.
  always_comb begin
    state_n    = state;
    in_idx_n   = in_idx;
    rem_n      = rem;
    kx_n       = kx;
    ky_n       = ky;
    dcnt_n     = dcnt;
    net_addr_n = net_addr;
    img_addr_n = img_addr;
    ack_n      = 1'b0;
    net_re_n   = 1'b0;
    img_re_n   = 1'b0;
    first_n    = first_input;
    last_n     = last_input;
    mask_n     = core_mask;
    wc_clear   = 1'b0;
    wc_load    = 1'b0;
    wc_adv     = 1'b0;
    kmax       = bus.conv_size - ONE;
    in_last    = bus.total_in - ONE;

    if (bus.abort) begin
      state_n    = ST_IDLE;
      in_idx_n   = '0;
      rem_n      = '0;
      kx_n       = '0;
      ky_n       = '0;
      dcnt_n     = '0;
      net_addr_n = '0;
      img_addr_n = '0;
      first_n    = 1'b0;
      last_n     = 1'b0;
      mask_n     = '0;
      wc_clear   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            if (bus.total_in == '0 || bus.total_out == '0) begin
              state_n = ST_DONE;
              ack_n   = 1'b1;
            end else begin
              state_n    = ST_NETLOAD;
              in_idx_n   = '0;
              rem_n      = bus.total_out;
              kx_n       = '0;
              ky_n       = '0;
              net_addr_n = bus.net_offset;
              img_addr_n = bus.in_offset;
              net_re_n   = 1'b1;
              first_n    = 1'b1;
              last_n     = (bus.total_in == ONE);
              mask_n     = mask_for(bus.total_out);
            end
          end
        end

        ST_NETLOAD: begin
          net_addr_n = net_addr + NETSIZE'(1);
          if (kx == kmax && ky == kmax) begin
            state_n  = ST_STREAM;
            wc_load  = 1'b1;
            img_re_n = 1'b1;
          end else begin
            net_re_n = 1'b1;
            if (kx == kmax) begin
              kx_n = '0;
              ky_n = ky + ONE;
            end else begin
              kx_n = kx + ONE;
            end
          end
        end

        ST_STREAM: begin
          img_addr_n = img_addr + IMGSIZE'(1);
          if (!wc_last) begin
            wc_adv   = 1'b1;
            img_re_n = 1'b1;
          end else if (in_idx != in_last) begin
            // next input channel, same group
            state_n  = ST_NETLOAD;
            in_idx_n = in_idx + ONE;
            kx_n     = '0;
            ky_n     = '0;
            net_re_n = 1'b1;
            first_n  = 1'b0;
            last_n   = (in_idx + ONE == in_last);
          end else if (rem > CORE_L) begin
            // next group: image pointer rewinds, weights keep running
            state_n    = ST_NETLOAD;
            rem_n      = rem - CORE_L;
            in_idx_n   = '0;
            img_addr_n = bus.in_offset;
            kx_n       = '0;
            ky_n       = '0;
            net_re_n   = 1'b1;
            first_n    = 1'b1;
            last_n     = (bus.total_in == ONE);
            mask_n     = mask_for(rem - CORE_L);
          end else begin
            first_n = 1'b0;
            last_n  = 1'b0;
            mask_n  = '0;
            if (DRAIN == 0) begin
              state_n = ST_DONE;
              ack_n   = 1'b1;
            end else begin
              state_n = ST_DRAIN;
              dcnt_n  = '0;
            end
          end
        end

        ST_DRAIN: begin
          if (dcnt == DRAIN_LAST) begin
            state_n = ST_DONE;
            ack_n   = 1'b1;
          end else begin
            dcnt_n = dcnt + ONE;
          end
        end

        ST_DONE: state_n = ST_IDLE;

        default: state_n = ST_IDLE;
      endcase
    end
    core_state_n = core_state_of(state_n);
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state       <= ST_IDLE;
      in_idx      <= '0;
      rem         <= '0;
      kx          <= '0;
      ky          <= '0;
      dcnt        <= '0;
      net_addr    <= '0;
      img_addr    <= '0;
      ack         <= 1'b0;
      core_state  <= CS_IDLE;
      net_re      <= 1'b0;
      img_re      <= 1'b0;
      first_input <= 1'b0;
      last_input  <= 1'b0;
      core_mask   <= '0;
    end else begin
      state       <= state_n;
      in_idx      <= in_idx_n;
      rem         <= rem_n;
      kx          <= kx_n;
      ky          <= ky_n;
      dcnt        <= dcnt_n;
      net_addr    <= net_addr_n;
      img_addr    <= img_addr_n;
      ack         <= ack_n;
      core_state  <= core_state_n;
      net_re      <= net_re_n;
      img_re      <= img_re_n;
      first_input <= first_n;
      last_input  <= last_n;
      core_mask   <= mask_n;
    end
  end

  assign bus.ack         = ack;
  assign bus.core_state  = core_state;
  assign bus.net_re      = net_re;
  assign bus.net_addr    = net_addr;
  assign bus.img_re      = img_re;
  assign bus.img_addr    = img_addr;
  assign bus.first_input = first_input;
  assign bus.last_input  = last_input;
  assign bus.core_mask   = core_mask;
  assign bus.win_oe      = win_oe;

endmodule

// File: tb/tb_renkon_ctrl_loop.sv
// Bench for renkon_ctrl_loop: per-cycle comparison against an arithmetic
// model of the loop nest (cycle index -> group/input/phase/pixel).
module tb_renkon_ctrl_loop;

  localparam int CORE = 8;
  localparam int LW   = 10;
  localparam int IW   = 12;
  localparam int NW   = 11;
  localparam int DR   = 4;

  logic clk  = 1'b0;
  logic xrst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  renkon_ctrl_loop_if #(.CORE(CORE), .LWIDTH(LW), .IMGSIZE(IW), .NETSIZE(NW)) bus ();

  renkon_ctrl_loop #(
    .CORE(CORE), .LWIDTH(LW), .IMGSIZE(IW), .NETSIZE(NW), .DRAIN(DR)
  ) dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_ack"},        32'(bus.ack),         32'd0);
    chk({p, "_core_state"}, 32'(bus.core_state),  32'd0);
    chk({p, "_net_re"},     32'(bus.net_re),      32'd0);
    chk({p, "_img_re"},     32'(bus.img_re),      32'd0);
    chk({p, "_win_oe"},     32'(bus.win_oe),      32'd0);
    chk({p, "_first"},      32'(bus.first_input), 32'd0);
    chk({p, "_last"},       32'(bus.last_input),  32'd0);
    chk({p, "_net_addr"},   32'(bus.net_addr),    32'd0);
    chk({p, "_img_addr"},   32'(bus.img_addr),    32'd0);
    chk({p, "_core_mask"},  32'(bus.core_mask),   32'd0);
  endtask

  function automatic int wins_1d(input int n, input int k, input int s);
    if (n < k) return 0;
    return (n - k) / s + 1;
  endfunction

  // Runs one layer from a negedge; optional abort / busy req / reset injection
  // at a given cycle number (0 = none). Returns positioned at a negedge, idle.
  task automatic run_layer(input int tout, input int tin, input int img, input int conv,
                           input int strd, input int ioff, input int noff,
                           input int abort_at, input int busy_req_at, input int rst_at);
    int s, k2, p, blk, g_n, work, done_c;
    int idx, ph, o, g, i, pix, x, y, rem_last;
    int e_state, e_ack, e_nre, e_ire, e_win, e_first, e_last, e_mask, e_na, e_ia;
    int n_net, n_img, n_win;
    s   = (strd == 0) ? 1 : strd;
    k2  = conv * conv;
    p   = img * img;
    blk = k2 + p;
    g_n = (tout + CORE - 1) / CORE;
    if (tin == 0 || tout == 0) begin
      work = 0; done_c = 1;
    end else begin
      work = g_n * tin * blk; done_c = work + DR + 1;
    end
    n_net = 0; n_img = 0; n_win = 0;

    bus.total_out  = LW'(tout);
    bus.total_in   = LW'(tin);
    bus.img_size   = LW'(img);
    bus.conv_size  = LW'(conv);
    bus.stride     = LW'(strd);
    bus.in_offset  = IW'(ioff);
    bus.net_offset = NW'(noff);
    bus.req        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;

    for (int c = 1; c <= done_c + 1; c++) begin
      e_state = 0; e_ack = 0; e_nre = 0; e_ire = 0; e_win = 0;
      e_first = 0; e_last = 0; e_mask = 0; e_na = 0; e_ia = 0;
      if (c <= work) begin
        idx = c - 1; ph = idx / blk; o = idx % blk; g = ph / tin; i = ph % tin;
        e_first = (i == 0) ? 1 : 0;
        e_last  = (i == tin - 1) ? 1 : 0;
        rem_last = tout - (g_n - 1) * CORE;
        e_mask  = (g == g_n - 1) ? ((1 << rem_last) - 1) : ((1 << CORE) - 1);
        if (o < k2) begin
          e_state = 1; e_nre = 1;
          e_na = (noff + ph * k2 + o) % (1 << NW);
        end else begin
          pix = o - k2; y = pix / img; x = pix % img;
          e_state = 2; e_ire = 1;
          e_ia = (ioff + i * p + pix) % (1 << IW);
          e_win = ((y >= conv - 1) && (x >= conv - 1) &&
                   ((y - conv + 1) % s == 0) && ((x - conv + 1) % s == 0)) ? 1 : 0;
        end
      end else if (c < done_c) begin
        e_state = 3;
      end else if (c == done_c) begin
        e_state = 3; e_ack = 1;
      end

      chk($sformatf("c%0d_core_state", c), 32'(bus.core_state), e_state);
      chk($sformatf("c%0d_ack", c),        32'(bus.ack),        e_ack);
      chk($sformatf("c%0d_net_re", c),     32'(bus.net_re),     e_nre);
      chk($sformatf("c%0d_img_re", c),     32'(bus.img_re),     e_ire);
      chk($sformatf("c%0d_win_oe", c),     32'(bus.win_oe),     e_win);
      if (e_nre != 0) chk($sformatf("c%0d_net_addr", c), 32'(bus.net_addr), e_na);
      if (e_ire != 0) chk($sformatf("c%0d_img_addr", c), 32'(bus.img_addr), e_ia);
      if (c <= work) begin
        chk($sformatf("c%0d_first", c),     32'(bus.first_input), e_first);
        chk($sformatf("c%0d_last", c),      32'(bus.last_input),  e_last);
        chk($sformatf("c%0d_core_mask", c), 32'(bus.core_mask),   e_mask);
      end
      n_net += int'(bus.net_re);
      n_img += int'(bus.img_re);
      n_win += int'(bus.win_oe);

      if (c == busy_req_at) bus.req = 1'b1;
      if (c == abort_at) begin
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.req   = 1'b0;
        chk_reset("abort");
        @(negedge clk);
        chk("abort_no_ack", 32'(bus.ack), 32'd0);
        chk("abort_idle",   32'(bus.core_state), 32'd0);
        return;
      end
      if (c == rst_at) begin
        #1 xrst = 1'b0;
        #1 chk_reset("xrst");
        @(negedge clk);
        xrst    = 1'b1;
        bus.req = 1'b0;
        @(negedge clk);
        chk_reset("post_xrst");
        return;
      end
      @(negedge clk);
      bus.req = 1'b0;
    end

    chk("count_net_re", n_net, g_n * tin * k2);
    chk("count_img_re", n_img, g_n * tin * p);
    chk("count_win_oe", n_win, g_n * tin * wins_1d(img, conv, s) * wins_1d(img, conv, s));
  endtask

  initial begin
    bus.req = 1'b0; bus.abort = 1'b0;
    bus.total_in = '0; bus.total_out = '0; bus.img_size = '0;
    bus.conv_size = '0; bus.stride = '0; bus.in_offset = '0; bus.net_offset = '0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    xrst = 1'b1;
    @(negedge clk);

    // three groups, partial last group, image pointer rewinds per group
    run_layer(20, 1, 4, 3, 1, 12'h100, 11'h040, 0, 0, 0);
    // two inputs, ack at cycle 55
    run_layer(8, 2, 4, 3, 1, 12'h020, 11'h010, 0, 0, 0);
    // stride 2 -> 4 strobes, stride 1 -> 9, stride 0 behaves as 1
    run_layer(1, 1, 5, 3, 2, 0, 0, 0, 0, 0);
    run_layer(1, 1, 5, 3, 1, 0, 0, 0, 0, 0);
    run_layer(3, 2, 5, 3, 0, 7, 9, 0, 0, 0);
    // empty layers complete in cycle 1
    run_layer(0, 2, 4, 3, 1, 0, 0, 0, 0, 0);
    run_layer(5, 0, 4, 3, 1, 0, 0, 0, 0, 0);
    // abort mid-STREAM, then a clean layer
    run_layer(8, 2, 4, 3, 1, 12'h030, 11'h005, 20, 0, 0);
    run_layer(8, 2, 4, 3, 1, 12'h030, 11'h005, 0, 0, 0);
    // abort together with req in IDLE keeps it idle
    bus.req = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.req = 1'b0; bus.abort = 1'b0;
    chk("abort_req_idle", 32'(bus.core_state), 32'd0);
    chk("abort_req_no_re", 32'(bus.net_re), 32'd0);
    // busy req ignored, then reset mid-NETLOAD
    run_layer(8, 2, 4, 3, 1, 12'h011, 11'h022, 0, 12, 28);
    run_layer(9, 1, 3, 2, 1, 12'hFFE, 11'h7FC, 0, 0, 0);

    // randomized layers, offsets allowed to wrap
    for (int n = 0; n < 10; n++) begin
      run_layer(int'($urandom_range(1, 20)), int'($urandom_range(1, 3)),
                int'($urandom_range(1, 6)),  int'($urandom_range(1, 3)),
                int'($urandom_range(0, 3)),  int'($urandom_range(0, 4095)),
                int'($urandom_range(0, 2047)), 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
